// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with writeback bypass and branch-mispredict flush
//   clk_in, rst_in (async, active-high), rdy_in (global enable: low holds everything)
//   issue_*       : allocate an entry at the tail; full / tail_rob_id report occupancy and the next id
//   wb_*          : result broadcast marking an entry ready (wb_taken = actual branch outcome)
//   rob_id_j/k    : lookup ids; ready_j/k, data_j/k give combinational operand status with bypass
//   commit_*      : registered retirement of the head entry; commit_reg_id = 0 means no commit
//   flush, flush_pc : registered mispredict recovery request and redirect PC
module reorder_buffer #(
    parameter int ROB_WIDTH = 3,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [REG_WIDTH-1:0] issue_reg_id,
    input  logic                 issue_ready,
    input  logic [31:0]          issue_data,
    input  logic                 issue_is_branch,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_alt_pc,
    output logic                 full,
    output logic [ROB_WIDTH-1:0] tail_rob_id,
    input  logic                 wb_valid,
    input  logic [ROB_WIDTH-1:0] wb_rob_id,
    input  logic [31:0]          wb_data,
    input  logic                 wb_taken,
    input  logic [ROB_WIDTH-1:0] rob_id_j,
    input  logic [ROB_WIDTH-1:0] rob_id_k,
    output logic                 ready_j,
    output logic [31:0]          data_j,
    output logic                 ready_k,
    output logic [31:0]          data_k,
    output logic [REG_WIDTH-1:0] commit_reg_id,
    output logic [31:0]          commit_data,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic                 flush,
    output logic [31:0]          flush_pc
);
    localparam int DEPTH = 1 << ROB_WIDTH;

    logic [REG_WIDTH-1:0] reg_q [DEPTH], reg_d [DEPTH];
    logic [31:0]          data_q [DEPTH], data_d [DEPTH];
    logic [31:0]          alt_q [DEPTH], alt_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d, ready_q, ready_d;
    logic [DEPTH-1:0]     br_q, br_d, pred_q, pred_d, taken_q, taken_d;
    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;
    logic [REG_WIDTH-1:0] commit_reg_q, commit_reg_d;
    logic [31:0]          commit_data_q, commit_data_d;
    logic [ROB_WIDTH-1:0] commit_rob_q, commit_rob_d;
    logic                 flush_q, flush_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic issue_ok, wb_ok, retire, mispredict;

    assign full        = count_q == (ROB_WIDTH+1)'(DEPTH);
    assign tail_rob_id = tail_q;
    // Duplicate or stale writebacks (empty or already-ready entries) are dropped.
    assign issue_ok    = issue_valid && !full && !flush_q && rdy_in;
    assign wb_ok       = rdy_in && wb_valid && !flush_q && valid_q[wb_rob_id] && !ready_q[wb_rob_id];
    // Retirement looks only at the registered ready bit, so a result needs one full cycle before it can retire.
    assign retire      = rdy_in && count_q != '0 && ready_q[head_q];
    assign mispredict  = retire && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

    assign ready_j = ready_q[rob_id_j] || (wb_valid && wb_rob_id == rob_id_j);
    assign data_j  = (wb_valid && wb_rob_id == rob_id_j) ? wb_data : data_q[rob_id_j];
    assign ready_k = ready_q[rob_id_k] || (wb_valid && wb_rob_id == rob_id_k);
    assign data_k  = (wb_valid && wb_rob_id == rob_id_k) ? wb_data : data_q[rob_id_k];

    assign commit_reg_id = commit_reg_q;
    assign commit_data   = commit_data_q;
    assign commit_rob_id = commit_rob_q;
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;

    always_comb begin
        reg_d         = reg_q;
        data_d        = data_q;
        alt_d         = alt_q;
        valid_d       = valid_q;
        ready_d       = ready_q;
        br_d          = br_q;
        pred_d        = pred_q;
        taken_d       = taken_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q + (ROB_WIDTH+1)'(issue_ok) - (ROB_WIDTH+1)'(retire);
        commit_reg_d  = commit_reg_q;
        commit_data_d = commit_data_q;
        commit_rob_d  = commit_rob_q;
        flush_d       = flush_q;
        flush_pc_d    = flush_pc_q;
        if (rdy_in) begin
            // Branches never name a destination register, even if the decoder supplied one.
            commit_reg_d  = (retire && !br_q[head_q]) ? reg_q[head_q] : '0;
            commit_data_d = retire ? data_q[head_q] : commit_data_q;
            commit_rob_d  = retire ? head_q : commit_rob_q;
            flush_d       = mispredict;
            flush_pc_d    = mispredict ? alt_q[head_q] : flush_pc_q;
        end
        if (issue_ok) begin
            reg_d[tail_q]   = issue_reg_id;
            data_d[tail_q]  = issue_data;
            alt_d[tail_q]   = issue_alt_pc;
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = issue_ready;
            br_d[tail_q]    = issue_is_branch;
            pred_d[tail_q]  = issue_pred_taken;
            taken_d[tail_q] = 1'b0;
            tail_d          = tail_q + 1'b1;
        end
        if (wb_ok) begin
            ready_d[wb_rob_id] = 1'b1;
            data_d[wb_rob_id]  = wb_data;
            taken_d[wb_rob_id] = wb_taken;
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        // A mispredict squashes everything younger, including an issue accepted this same edge.
        if (mispredict) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
                alt_q[i]  <= '0;
            end
            valid_q       <= '0;
            ready_q       <= '0;
            br_q          <= '0;
            pred_q        <= '0;
            taken_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_reg_q  <= '0;
            commit_data_q <= '0;
            commit_rob_q  <= '0;
            flush_q       <= 1'b0;
            flush_pc_q    <= '0;
        end else begin
            reg_q         <= reg_d;
            data_q        <= data_d;
            alt_q         <= alt_d;
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            br_q          <= br_d;
            pred_q        <= pred_d;
            taken_q       <= taken_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_reg_q  <= commit_reg_d;
            commit_data_q <= commit_data_d;
            commit_rob_q  <= commit_rob_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
    logic        clk_in = 0, rst_in = 1, rdy_in = 1;
    logic        issue_valid = 0, issue_ready = 0, issue_is_branch = 0, issue_pred_taken = 0;
    logic [4:0]  issue_reg_id = 0;
    logic [31:0] issue_data = 0, issue_alt_pc = 0;
    logic        full;
    logic [2:0]  tail_rob_id;
    logic        wb_valid = 0, wb_taken = 0;
    logic [2:0]  wb_rob_id = 0, rob_id_j = 0, rob_id_k = 0;
    logic [31:0] wb_data = 0;
    logic        ready_j, ready_k;
    logic [31:0] data_j, data_k;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_data;
    logic [2:0]  commit_rob_id;
    logic        flush;
    logic [31:0] flush_pc;
    int tests = 0, fails = 0;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_reg_id(issue_reg_id), .issue_ready(issue_ready),
        .issue_data(issue_data), .issue_is_branch(issue_is_branch),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .full(full), .tail_rob_id(tail_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data), .wb_taken(wb_taken),
        .rob_id_j(rob_id_j), .rob_id_k(rob_id_k),
        .ready_j(ready_j), .data_j(data_j), .ready_k(ready_k), .data_k(data_k),
        .commit_reg_id(commit_reg_id), .commit_data(commit_data), .commit_rob_id(commit_rob_id),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_ready = 0; issue_is_branch = 0; issue_pred_taken = 0;
        issue_reg_id = 0; issue_data = 0; issue_alt_pc = 0;
        wb_valid = 0; wb_taken = 0; wb_rob_id = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        #2;
        rst_in = 0;
    endtask

    task automatic issue(input logic [4:0] r, input logic rdy, input logic [31:0] d);
        issue_valid = 1; issue_reg_id = r; issue_ready = rdy; issue_data = d;
        tick();
        idle();
    endtask

    task automatic wb(input logic [2:0] id, input logic [31:0] d, input logic t);
        wb_valid = 1; wb_rob_id = id; wb_data = d; wb_taken = t;
        tick();
        idle();
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_full", full, 0);
        chk("rst_tail", tail_rob_id, 0);
        chk("rst_commit", commit_reg_id, 0);
        chk("rst_flush", flush, 0);
        tick();
        rst_in = 0;

        // fill to full, ninth issue dropped
        for (int i = 0; i < 8; i++) begin
            chk("fill_notfull", full, 0);
            issue(5'(i + 1), 0, 0);
        end
        chk("full_after8", full, 1);
        chk("tail_after8", tail_rob_id, 0);
        issue(5'd20, 0, 0);
        chk("full_after9", full, 1);
        chk("tail_after9", tail_rob_id, 0);
        rst_in = 1;
        #1;
        chk("async_rst_full", full, 0);
        rst_in = 0;

        // single commit
        do_reset();
        issue(5'd5, 0, 0);
        wb(3'd0, 32'h1234, 0);
        chk("c1_none_yet", commit_reg_id, 0);
        tick();
        chk("c1_reg", commit_reg_id, 5);
        chk("c1_data", commit_data, 32'h1234);
        chk("c1_id", commit_rob_id, 0);
        tick();
        chk("c1_gone", commit_reg_id, 0);

        // reverse writeback, in-order commit
        do_reset();
        issue(5'd10, 0, 0);
        issue(5'd11, 0, 0);
        issue(5'd12, 0, 0);
        wb(3'd2, 32'h22, 0);
        wb(3'd1, 32'h11, 0);
        chk("ooo_no_commit", commit_reg_id, 0);
        wb(3'd0, 32'h00, 0);
        chk("ooo_still_none", commit_reg_id, 0);
        tick();
        chk("ooo_c0_reg", commit_reg_id, 10);
        chk("ooo_c0_id", commit_rob_id, 0);
        tick();
        chk("ooo_c1_reg", commit_reg_id, 11);
        chk("ooo_c1_data", commit_data, 32'h11);
        tick();
        chk("ooo_c2_reg", commit_reg_id, 12);
        chk("ooo_c2_id", commit_rob_id, 2);
        tick();
        chk("ooo_done", commit_reg_id, 0);

        // writeback bypass on lookup
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 1), 0, 0);
        rob_id_j = 3; rob_id_k = 2;
        wb_valid = 1; wb_rob_id = 3; wb_data = 32'hAA;
        #1;
        chk("byp_ready_j", ready_j, 1);
        chk("byp_data_j", data_j, 32'hAA);
        chk("byp_ready_k", ready_k, 0);
        tick();
        chk("entry_ready_j", ready_j, 1);
        chk("entry_data_j", data_j, 32'hAA);
        chk("byp_no_commit", commit_reg_id, 0);

        // mispredicted branch flush
        do_reset();
        issue_is_branch = 1; issue_alt_pc = 32'h100;
        issue(5'd0, 0, 0);
        issue(5'd7, 0, 0);
        issue(5'd8, 0, 0);
        wb(3'd0, 0, 1);
        chk("br_no_flush_yet", flush, 0);
        issue_valid = 1; issue_reg_id = 9;
        wb_valid = 1; wb_rob_id = 1; wb_data = 32'h77;
        tick();
        chk("br_flush", flush, 1);
        chk("br_flush_pc", flush_pc, 32'h100);
        chk("br_tail0", tail_rob_id, 0);
        chk("br_empty", full, 0);
        chk("br_commit0", commit_reg_id, 0);
        tick();
        idle();
        chk("br_flush_clear", flush, 0);
        chk("br_issue_ignored", tail_rob_id, 0);
        wb(3'd1, 32'h71, 0);
        wb(3'd2, 32'h72, 0);
        tick();
        chk("br_no_young_commit", commit_reg_id, 0);

        // correctly predicted branch
        do_reset();
        issue_is_branch = 1; issue_pred_taken = 1; issue_alt_pc = 32'h200;
        issue(5'd0, 0, 0);
        wb(3'd0, 32'h5, 1);
        tick();
        chk("okbr_no_flush", flush, 0);
        chk("okbr_reg0", commit_reg_id, 0);
        chk("okbr_data", commit_data, 32'h5);

        // rdy_in hold, then async reset mid-run
        do_reset();
        issue(5'd9, 1, 32'h55);
        issue(5'd3, 1, 32'h66);
        chk("hold_first", commit_reg_id, 9);
        rdy_in = 0;
        issue_valid = 1; issue_reg_id = 4; issue_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_reg", commit_reg_id, 9);
            chk("hold_data", commit_data, 32'h55);
        end
        chk("hold_tail", tail_rob_id, 2);
        idle();
        rdy_in = 1;
        tick();
        chk("resume_reg", commit_reg_id, 3);
        chk("resume_data", commit_data, 32'h66);
        chk("resume_id", commit_rob_id, 1);
        issue_valid = 1; issue_reg_id = 6; issue_ready = 1;
        tick();
        rdy_in = 0;
        #2;
        rst_in = 1;
        #1;
        chk("mid_rst_reg", commit_reg_id, 0);
        chk("mid_rst_data", commit_data, 0);
        chk("mid_rst_id", commit_rob_id, 0);
        chk("mid_rst_flush", flush, 0);
        chk("mid_rst_tail", tail_rob_id, 0);
        chk("mid_rst_pc", flush_pc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
